vedic_seq_accumulator: RTL and testbench

Sequential multiplier stage that sits directly downstream of the 2x2 vedic core and consumes its 4-bit partial products. Accepts WIDTH-bit operands over a valid/ready handshake. Steps through every 2-bit digit pair of the operands, one pair per cycle, through one instantiated 2x2 vedic core. Shift-accumulates each partial product into a 2*WIDTH-bit result, then presents the result on an output valid/ready handshake.

---
 rtl/vedic_seq_accumulator.sv | 145 ++++++++++++++
 tb/tb_vedic_seq_accumulator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_accumulator.sv
// Sequential unsigned multiplier: walks every 2-bit digit pair of a and b through one
// 2x2 vedic core and shift-accumulates the partial products into a 2*WIDTH-bit product.

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_hi;
    logic cross_lo;
    logic carry;

    // Vertically-and-crosswise: the two cross terms form the middle bit and its carry
    assign cross_hi = a[1] & b[0];
    assign cross_lo = a[0] & b[1];
    assign carry    = cross_hi & cross_lo;

    assign p[0] = a[0] & b[0];
    assign p[1] = cross_hi ^ cross_lo;
    assign p[2] = (a[1] & b[1]) ^ carry;
    assign p[3] = (a[1] & b[1]) & carry;
endmodule

module vedic_seq_accumulator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);
    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("vedic_seq_accumulator: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_cap;
    logic [WIDTH-1:0]   b_cap;
    logic [IDX_W-1:0]   i;
    logic [IDX_W-1:0]   j;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_sum;
    logic [PW-1:0]      term;
    logic [SUM_W-1:0]   ij_sum;
    logic [1:0]         a_dig;
    logic [1:0]         b_dig;
    logic [3:0]         pp;
    logic               i_last;
    logic               last_pair;

    assign a_dig     = 2'(a_cap >> {i, 1'b0});
    assign b_dig     = 2'(b_cap >> {j, 1'b0});
    assign i_last    = (i == IDX_W'(N - 1));
    assign last_pair = i_last && (j == IDX_W'(N - 1));

    vedic_2x2 u_core (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // Partial product weighted by 2^(2*(i+j))
    assign ij_sum  = SUM_W'(i) + SUM_W'(j);
    assign term    = PW'(pp) << {ij_sum, 1'b0};
    assign acc_sum = acc + term;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_pair) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; handshake/status flags are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap <= '0;
            b_cap <= '0;
            i     <= '0;
            j     <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_cap <= a;
                        b_cap <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (i_last) begin
                        i <= '0;
                        j <= j + IDX_W'(1);
                    end else begin
                        i <= i + IDX_W'(1);
                    end
                    if (last_pair) begin
                        p <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_seq_accumulator.sv
// Randomized self-checking bench for vedic_seq_accumulator against a plain a*b model.

module tb_vedic_seq_accumulator;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned LAT   = N * N;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    int tests    = 0;
    int failures = 0;
    logic [2*WIDTH-1:0] last_p;

    vedic_seq_accumulator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for out_valid after an accepting edge; checks RUN-phase flags and latency
    task automatic wait_result(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid !== 1'b1) begin
                check_eq("run_in_ready", 64'(in_ready), 64'd0);
                check_eq("run_busy", 64'(busy), 64'd1);
                check_eq("run_p_held", 64'(p), 64'(last_p));
                out_ready = 1'($urandom);
            end
        end
    endtask

    // One full operation; called at posedge+1 with the DUT in IDLE
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input int hold, input bit poke);
        logic [2*WIDTH-1:0] exp;
        int n;
        exp = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
        check_eq("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = op_a;
        b = op_b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        check_eq("accept_busy", 64'(busy), 64'd1);
        wait_result(n);
        check_eq("latency", 64'(n), 64'(LAT));
        check_eq("product", 64'(p), 64'(exp));
        check_eq("done_busy", 64'(busy), 64'd1);
        check_eq("done_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke && k == 0) begin
                in_valid = 1'b1;
                a = 8'h02;
                b = 8'h02;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_p", 64'(p), 64'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("exit_valid", 64'(out_valid), 64'd0);
        check_eq("exit_in_ready", 64'(in_ready), 64'd1);
        check_eq("exit_busy", 64'(busy), 64'd0);
        check_eq("exit_p_kept", 64'(p), 64'(exp));
        last_p = exp;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        last_p    = '0;
        #12;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_p", 64'(p), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(8'hFF, 8'hFF, 3, 1'b0);
        run_op(8'hA5, 8'h3C, 0, 1'b0);
        run_op(8'h00, 8'h7B, 0, 1'b0);
        run_op(8'h01, 8'h80, 1, 1'b0);
        run_op(8'h03, 8'h07, 5, 1'b1);

        // Back-to-back with in_valid held high throughout
        in_valid  = 1'b1;
        a         = 8'h03;
        b         = 8'h07;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hC8;
        b = 8'h02;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("b2b_lat0", 64'(n), 64'(LAT));
        check_eq("b2b_p0", 64'(p), 64'h0015);
        @(posedge clk);
        #1;
        check_eq("b2b_gap_ready", 64'(in_ready), 64'd1);
        check_eq("b2b_gap_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("b2b_accept2", 64'(busy), 64'd1);
        last_p = 16'h0015;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("b2b_lat1", 64'(n), 64'(LAT));
        check_eq("b2b_p1", 64'(p), 64'h0190);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        last_p = 16'h0190;

        // Reset in the middle of RUN
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_p", 64'(p), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        last_p = '0;
        @(posedge clk);
        #1;
        run_op(8'h10, 8'h10, 0, 1'b0);

        // Randomized operations
        for (int t = 0; t < 20; t++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
